// File: rtl/easyaxi_rd_arb_pkg.sv
// Purpose: shared AXI read-channel field widths, packed AR/R widths and arbiter state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package easyaxi_rd_arb_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_RESP_W  = 2;
    localparam int AXI_USER_W  = 1;

    // AR payload: {arid, araddr, arlen, arsize, arburst, aruser}
    localparam int AXI_AR_W = AXI_ID_W + AXI_ADDR_W + AXI_LEN_W + AXI_SIZE_W
                            + AXI_BURST_W + AXI_USER_W;
    // R payload: {rid, rdata, rresp, rlast, ruser}
    localparam int AXI_R_W  = AXI_ID_W + AXI_DATA_W + AXI_RESP_W + 1 + AXI_USER_W;

    // rlast sits directly above ruser in the packed R payload
    localparam int R_LAST_BIT = AXI_USER_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic r_is_last(input logic [AXI_R_W-1:0] r);
        return r[R_LAST_BIT];
    endfunction

endpackage

// File: rtl/easyaxi_ost_cnt.sv
// Purpose: per-master outstanding read-burst counter, saturating at 0 and flagging underflow.
// Latency: count updates one cycle after inc/dec; full/empty/underflow are combinational.
// Backpressure: none itself; full is used upstream to stop granting that master.
module easyaxi_ost_cnt #(
    parameter int OST_DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic underflow
);

    localparam int CNT_W = $clog2(OST_DEPTH + 1);

    logic [CNT_W-1:0] cnt;

    assign full      = (cnt == CNT_W'(OST_DEPTH));
    assign empty     = (cnt == '0);
    // An inc in the same cycle accounts for the burst being retired, so no underflow then
    assign underflow = dec & ~inc & empty;

    // Count up on AR issue, down on burst completion; simultaneous inc+dec cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc & ~dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec & ~inc & ~empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// Purpose: 2:1 AXI read arbiter; round-robin AR grant with master index as ARID MSB, R routed by RID MSB.
// Latency: AR valid -> slave AR valid after 1 cycle, 1 AR per 2 cycles max; R path is 0-cycle combinational.
// Backpressure: slave arready passes to the granted master only; a master at OST_DEPTH outstanding is not granted.
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int OST_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_arvalid,
    output logic                 m0_arready,
    input  logic [AXI_AR_W-1:0]  m0_ar,
    input  logic                 m1_arvalid,
    output logic                 m1_arready,
    input  logic [AXI_AR_W-1:0]  m1_ar,

    output logic                 s_arvalid,
    input  logic                 s_arready,
    output logic [AXI_AR_W:0]    s_ar,

    input  logic                 s_rvalid,
    output logic                 s_rready,
    input  logic [AXI_R_W:0]     s_r,

    output logic                 m0_rvalid,
    input  logic                 m0_rready,
    output logic [AXI_R_W-1:0]   m0_r,
    output logic                 m1_rvalid,
    input  logic                 m1_rready,
    output logic [AXI_R_W-1:0]   m1_r,

    output logic                 busy,
    output logic                 err
);

    arb_state_t state;
    logic       gnt_idx;
    logic       rr_ptr;

    logic full0, full1;
    logic empty0, empty1;
    logic uflow0, uflow1;
    logic elig0, elig1;
    logic ar_hs;
    logic inc0, inc1, dec0, dec1;
    logic r_sel;

    assign elig0 = m0_arvalid & ~full0;
    assign elig1 = m1_arvalid & ~full1;

    // AR mux: only the granted master is visible to the slave while in GRANT
    always_comb begin
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_ar       = {gnt_idx, (gnt_idx ? m1_ar : m0_ar)};
        if (state == ST_GRANT) begin
            s_arvalid  = gnt_idx ? m1_arvalid : m0_arvalid;
            m0_arready = ~gnt_idx & s_arready;
            m1_arready =  gnt_idx & s_arready;
        end
    end

    assign ar_hs = s_arvalid & s_arready;

    // Grant FSM: pick an eligible master in IDLE, hold it until its AR handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt_idx <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (elig0 | elig1) begin
                        state   <= ST_GRANT;
                        gnt_idx <= (elig0 & elig1) ? rr_ptr : elig1;
                    end
                end
                ST_GRANT: begin
                    if (ar_hs) begin
                        rr_ptr <= ~gnt_idx;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // R demux: RID MSB names the master; payload goes to both with the MSB stripped
    always_comb begin
        r_sel     = s_r[AXI_R_W];
        m0_r      = s_r[AXI_R_W-1:0];
        m1_r      = s_r[AXI_R_W-1:0];
        m0_rvalid = s_rvalid & ~r_sel;
        m1_rvalid = s_rvalid &  r_sel;
        s_rready  = r_sel ? m1_rready : m0_rready;
    end

    assign inc0 = ar_hs & ~gnt_idx;
    assign inc1 = ar_hs &  gnt_idx;
    assign dec0 = m0_rvalid & m0_rready & r_is_last(m0_r);
    assign dec1 = m1_rvalid & m1_rready & r_is_last(m1_r);

    easyaxi_ost_cnt #(.OST_DEPTH(OST_DEPTH)) u_cnt0 (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc0),
        .dec       (dec0),
        .full      (full0),
        .empty     (empty0),
        .underflow (uflow0)
    );

    easyaxi_ost_cnt #(.OST_DEPTH(OST_DEPTH)) u_cnt1 (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc1),
        .dec       (dec1),
        .full      (full1),
        .empty     (empty1),
        .underflow (uflow1)
    );

    assign busy = (state == ST_GRANT) | ~empty0 | ~empty1;

    // Sticky error: a burst completed for a master that had nothing outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (uflow0 | uflow1) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Purpose: directed scenarios plus randomized traffic against a cycle-level reference model.
// Latency: model predicts every output each cycle from its own owner/preference/count bookkeeping.
// Backpressure: random slave arready and master rready exercise both stall directions.
module tb_easyaxi_rd_arb;
    import easyaxi_rd_arb_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                m_arvalid [2];
    logic                m_arready [2];
    logic [AXI_AR_W-1:0] m_ar      [2];
    logic                s_arvalid;
    logic                s_arready;
    logic [AXI_AR_W:0]   s_ar;
    logic                s_rvalid;
    logic                s_rready;
    logic [AXI_R_W:0]    s_r;
    logic                m_rvalid  [2];
    logic                m_rready  [2];
    logic [AXI_R_W-1:0]  m_r       [2];
    logic                busy;
    logic                err;

    easyaxi_rd_arb #(.OST_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_arvalid (m_arvalid[0]),
        .m0_arready (m_arready[0]),
        .m0_ar      (m_ar[0]),
        .m1_arvalid (m_arvalid[1]),
        .m1_arready (m_arready[1]),
        .m1_ar      (m_ar[1]),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_ar       (s_ar),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .s_r        (s_r),
        .m0_rvalid  (m_rvalid[0]),
        .m0_rready  (m_rready[0]),
        .m0_r       (m_r[0]),
        .m1_rvalid  (m_rvalid[1]),
        .m1_rready  (m_rready[1]),
        .m1_r       (m_r[1]),
        .busy       (busy),
        .err        (err)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int owner = -1;   // master currently holding the grant, -1 when none
    int pref  = 0;    // master favoured on a tie
    int mcnt [2] = '{0, 0};
    bit merr = 1'b0;
    int gnt_log [$];
    bit last_ar_hs [2];
    bit last_r_hs;

    // Slave-side burst bookkeeping for random R generation
    logic [4:0] bq_id  [$];
    int         bq_len [$];
    int         r_beat = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AXI_AR_W-1:0] make_ar(input logic [3:0] id, input logic [7:0] len);
        logic [31:0] a;
        a = $urandom;
        return {id, a, len, 3'd2, 2'b01, 1'b0};
    endfunction

    function automatic logic [AXI_R_W:0] make_r(input logic [4:0] id, input logic last);
        logic [31:0] d;
        d = $urandom;
        return {id, d, 2'b00, last, 1'b0};
    endfunction

    // One clock: compare outputs at negedge, then advance the model on the posedge
    task automatic cycle();
        int sel;
        bit ar_hs, r_hs, e0, e1;
        bit inc [2];
        bit dec [2];
        logic [AXI_AR_W-1:0] cur;
        @(negedge clk);
        sel = int'(s_r[AXI_R_W]);
        check("s_arvalid", s_arvalid, (owner >= 0) && m_arvalid[owner]);
        if ((owner >= 0) && m_arvalid[owner])
            check("s_ar", s_ar, {owner[0], m_ar[owner]});
        check("m0_arready", m_arready[0], (owner == 0) && s_arready);
        check("m1_arready", m_arready[1], (owner == 1) && s_arready);
        check("m0_rvalid", m_rvalid[0], s_rvalid && (sel == 0));
        check("m1_rvalid", m_rvalid[1], s_rvalid && (sel == 1));
        check("m0_r", m_r[0], s_r[AXI_R_W-1:0]);
        check("m1_r", m_r[1], s_r[AXI_R_W-1:0]);
        check("s_rready", s_rready, m_rready[sel]);
        check("busy", busy, (owner >= 0) || (mcnt[0] != 0) || (mcnt[1] != 0));
        check("err", err, merr);
        check("cnt0", dut.u_cnt0.cnt, mcnt[0]);
        check("cnt1", dut.u_cnt1.cnt, mcnt[1]);

        @(posedge clk);
        last_ar_hs[0] = 1'b0;
        last_ar_hs[1] = 1'b0;
        last_r_hs     = 1'b0;
        if (rst) begin
            owner = -1; pref = 0; mcnt[0] = 0; mcnt[1] = 0; merr = 1'b0;
        end else begin
            ar_hs = (owner >= 0) && m_arvalid[owner] && s_arready;
            r_hs  = s_rvalid && m_rready[sel];
            for (int i = 0; i < 2; i++) begin
                inc[i] = ar_hs && (owner == i);
                dec[i] = r_hs && (sel == i) && s_r[R_LAST_BIT];
            end
            if (owner < 0) begin
                e0 = m_arvalid[0] && (mcnt[0] != DEPTH);
                e1 = m_arvalid[1] && (mcnt[1] != DEPTH);
                if (e0 && e1) owner = pref;
                else if (e0)  owner = 0;
                else if (e1)  owner = 1;
            end else if (ar_hs) begin
                cur = m_ar[owner];
                bq_id.push_back({owner[0], cur[AXI_AR_W-1 -: 4]});
                bq_len.push_back(int'(cur[13:6]));
                gnt_log.push_back(owner);
                pref  = 1 - owner;
                owner = -1;
            end
            for (int i = 0; i < 2; i++) begin
                if (inc[i] && !dec[i]) mcnt[i]++;
                else if (dec[i] && !inc[i]) begin
                    if (mcnt[i] == 0) merr = 1'b1;
                    else mcnt[i]--;
                end
                last_ar_hs[i] = inc[i];
            end
            last_r_hs = r_hs;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
        m_rready[0]  = 1'b0; m_rready[1]  = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0;
        cycle();
        rst = 1'b0;
        bq_id.delete(); bq_len.delete(); r_beat = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit got;
        rst = 1'b1;
        m_ar[0] = '0; m_ar[1] = '0; s_r = '0;
        m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
        m_rready[0] = 1'b0; m_rready[1] = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0;
        do_reset();
        check("rst_s_arvalid", s_arvalid, 1'b0);
        check("rst_busy", busy, 1'b0);

        // 1: single m0 burst, arid=3 arlen=3, four R beats back
        m_ar[0] = make_ar(4'd3, 8'd3);
        m_arvalid[0] = 1'b1;
        s_arready = 1'b1;
        cycle();
        check("t1_s_arvalid", s_arvalid, 1'b1);
        check("t1_s_arid", s_ar[AXI_AR_W -: 5], 5'b00011);
        cycle();
        check("t1_hs", last_ar_hs[0], 1'b1);
        m_arvalid[0] = 1'b0;
        check("t1_cnt_up", dut.u_cnt0.cnt, 5'd1);
        m_rready[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1;
            s_r = make_r(5'b00011, b == 3);
            cycle();
            check("t1_rid", m_r[0][AXI_R_W-1 -: 4], 4'd3);
        end
        s_rvalid = 1'b0;
        cycle();
        check("t1_cnt_down", dut.u_cnt0.cnt, 5'd0);

        // 2: both masters continuously valid -> strict alternation starting at m0
        do_reset();
        base = gnt_log.size();
        m_ar[0] = make_ar(4'd1, 8'd0);
        m_ar[1] = make_ar(4'd2, 8'd0);
        m_arvalid[0] = 1'b1; m_arvalid[1] = 1'b1;
        s_arready = 1'b1;
        for (int k = 0; k < 60 && gnt_log.size() < base + 12; k++) begin
            cycle();
            for (int i = 0; i < 2; i++)
                if (last_ar_hs[i]) m_ar[i] = make_ar(4'($urandom), 8'd0);
        end
        check("t2_count", gnt_log.size() - base, 12);
        for (int k = 0; k < 12 && base + k < gnt_log.size(); k++)
            check("t2_order", gnt_log[base + k], k % 2);

        // 3: m0 fills to 16 outstanding, 17th held, m1 still served, one rlast frees m0
        do_reset();
        m_ar[0] = make_ar(4'd5, 8'd0);
        m_arvalid[0] = 1'b1;
        s_arready = 1'b1;
        for (int k = 0; k < 80 && mcnt[0] < DEPTH; k++) begin
            cycle();
            if (last_ar_hs[0]) m_ar[0] = make_ar(4'd5, 8'd0);
        end
        repeat (3) cycle();
        check("t3_cnt_full", dut.u_cnt0.cnt, 5'd16);
        check("t3_held", s_arvalid, 1'b0);
        m_ar[1] = make_ar(4'd7, 8'd0);
        m_arvalid[1] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (last_ar_hs[1]) got = 1'b1;
        end
        m_arvalid[1] = 1'b0;
        check("t3_m1_granted", got, 1'b1);
        check("t3_m0_still_full", dut.u_cnt0.cnt, 5'd16);
        m_rready[0] = 1'b1;
        s_rvalid = 1'b1;
        s_r = make_r(5'b00101, 1'b1);
        cycle();
        s_rvalid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (last_ar_hs[0]) got = 1'b1;
        end
        m_arvalid[0] = 1'b0;
        check("t3_m0_freed", got, 1'b1);

        // 4: m1 AR handshake coincides with m1 rlast handshake
        do_reset();
        m_ar[1] = make_ar(4'd9, 8'd0);
        m_arvalid[1] = 1'b1;
        s_arready = 1'b1;
        cycle();
        cycle();
        m_ar[1] = make_ar(4'd9, 8'd0);
        cycle();
        check("t4_pre_cnt", dut.u_cnt1.cnt, 5'd1);
        m_rready[1] = 1'b1;
        s_rvalid = 1'b1;
        s_r = make_r(5'b11001, 1'b1);
        cycle();
        check("t4_both_hs", last_ar_hs[1] && last_r_hs, 1'b1);
        m_arvalid[1] = 1'b0;
        s_rvalid = 1'b0;
        cycle();
        check("t4_cnt_same", dut.u_cnt1.cnt, 5'd1);

        // 5: rlast for m1 with nothing outstanding -> sticky err
        do_reset();
        m_rready[1] = 1'b1;
        s_rvalid = 1'b1;
        s_r = make_r(5'b10000, 1'b1);
        cycle();
        s_rvalid = 1'b0;
        repeat (3) cycle();
        check("t5_err", err, 1'b1);
        check("t5_cnt1", dut.u_cnt1.cnt, 5'd0);
        do_reset();
        check("t5_err_clr", err, 1'b0);

        // 6: reset while granted and stalled
        m_ar[0] = make_ar(4'd2, 8'd0);
        m_arvalid[0] = 1'b1;
        s_arready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (last_ar_hs[0]) got = 1'b1;
        end
        s_arready = 1'b0;
        m_ar[0] = make_ar(4'd4, 8'd0);
        cycle();
        check("t6_granted", s_arvalid, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_s_arvalid", s_arvalid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_cnt0", dut.u_cnt0.cnt, 5'd0);
        check("t6_rr_ptr", dut.rr_ptr, 1'b0);
        m_arvalid[0] = 1'b0;

        // Random traffic: AXI-compliant masters, random slave stalls and R returns
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (last_ar_hs[i]) m_arvalid[i] = 1'b0;
                if (!m_arvalid[i] && ($urandom_range(2, 0) == 0)) begin
                    m_arvalid[i] = 1'b1;
                    m_ar[i] = make_ar(4'($urandom), 8'($urandom_range(3, 0)));
                end
                m_rready[i] = ($urandom_range(3, 0) != 0);
            end
            s_arready = ($urandom_range(3, 0) != 0);
            if (s_rvalid && last_r_hs) begin
                if (s_r[R_LAST_BIT]) begin
                    void'(bq_id.pop_front());
                    void'(bq_len.pop_front());
                    r_beat = 0;
                end else begin
                    r_beat++;
                end
                s_rvalid = 1'b0;
            end
            if (!s_rvalid && (bq_id.size() > 0) && ($urandom_range(1, 0) == 1)) begin
                s_rvalid = 1'b1;
                s_r = make_r(bq_id[0], r_beat == bq_len[0]);
            end
            cycle();
        end
        check("rnd_no_err", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
